// File: rtl/rv32i_dmem_responder.sv
// Word-addressed data-memory slave with programmable wait states,
// single outstanding request and valid/ready on request and response.
module rv32i_dmem_responder #(
   parameter int DEPTH       = 32,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             RN,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_err,
   output logic [CNT_W-1:0] acc_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WLOAD =
      (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_wcnt;
   logic             r_we;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [31:0]      r_rdata;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_mem [DEPTH];

   logic             w_accept;
   logic             w_hs;
   logic             w_access;
   logic             w_acc_we;
   logic [31:0]      w_acc_addr;
   logic [31:0]      w_acc_wdata;
   logic             w_in_range;
   logic [AW-1:0]    w_idx;

   assign req_ready = RN && (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign acc_cnt   = r_cnt;

   assign w_accept   = req_valid && req_ready;
   assign w_hs       = rsp_valid && rsp_ready;
   assign w_in_range = (w_acc_addr < 32'(DEPTH));
   assign w_idx      = w_acc_addr[AW-1:0];

   // With no wait states the access happens on the accept edge itself,
   // so the request is used straight from the port.
   always_comb begin
      w_next      = r_state;
      w_access    = 1'b0;
      w_acc_we    = r_we;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (WAIT_CYCLES == 0) begin
                  w_access    = 1'b1;
                  w_acc_we    = req_we;
                  w_acc_addr  = req_addr;
                  w_acc_wdata = req_wdata;
                  w_next      = RESP;
               end else begin
                  w_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (r_wcnt == 4'd0) begin
               w_access = 1'b1;
               w_next   = RESP;
            end
         end
         RESP: begin
            if (w_hs) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RN) begin
      if (!RN) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or negedge RN) begin
      if (!RN) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wcnt  <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wcnt  <= WLOAD;
         end else if (r_state == WAIT) begin
            r_wcnt <= r_wcnt - 4'd1;
         end
         if (w_access) begin
            r_err   <= !w_in_range;
            r_rdata <= (w_in_range && !w_acc_we) ? r_mem[w_idx] : '0;
         end
         if (w_hs) r_cnt <= r_cnt + 1'b1;
      end
   end

   // Storage survives reset; only a committed access edge writes it.
   always_ff @(posedge clk) begin
      if (w_access && w_acc_we && w_in_range)
         r_mem[w_idx] <= w_acc_wdata;
   end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed + random bench for rv32i_dmem_responder with an
// array/counter reference model; a second instance has no wait states.
module tb_rv32i_dmem_responder;

   localparam int W = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        RN;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [15:0] acc_cnt;

   logic        req_valid_z, req_ready_z, req_we_z;
   logic [31:0] req_addr_z, req_wdata_z;
   logic        rsp_valid_z, rsp_ready_z, rsp_err_z;
   logic [31:0] rsp_rdata_z;
   logic [3:0]  acc_cnt_z;

   rv32i_dmem_responder #(.DEPTH(32), .WAIT_CYCLES(W), .CNT_W(16)) dut (
      .clk(clk), .RN(RN),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .acc_cnt(acc_cnt)
   );

   rv32i_dmem_responder #(.DEPTH(32), .WAIT_CYCLES(0), .CNT_W(4)) dut0 (
      .clk(clk), .RN(RN),
      .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
      .req_addr(req_addr_z), .req_wdata(req_wdata_z),
      .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
      .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z), .acc_cnt(acc_cnt_z)
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] mem_m [32];
   logic [31:0] mem_z [32];
   logic [15:0] cnt_m;
   logic [3:0]  cnt_z;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit z, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err);
      if (a < 32) begin
         err = 1'b0;
         rd  = 32'd0;
         if (we) begin
            if (z) mem_z[a[4:0]] = wd;
            else   mem_m[a[4:0]] = wd;
         end else begin
            rd = z ? mem_z[a[4:0]] : mem_m[a[4:0]];
         end
      end else begin
         err = 1'b1;
         rd  = 32'd0;
      end
   endtask

   task automatic txn(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input int hold);
      logic [31:0] erd;
      logic        eerr;
      int          lat;
      chk("idle_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = $urandom;
      req_wdata = $urandom;
      model(1'b0, we, a, wd, erd, eerr);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("rsp_edges", 32'(lat), 32'(W + 1));
      chk("ready_in_resp", 32'(req_ready), 32'd0);
      chk("rdata", rsp_rdata, erd);
      chk("err", 32'(rsp_err), 32'(eerr));
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rdata", rsp_rdata, erd);
         chk("hold_cnt", 32'(acc_cnt), 32'(cnt_m));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      cnt_m++;
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
      chk("acc_cnt", 32'(acc_cnt), 32'(cnt_m));
   endtask

   task automatic txn_z(input logic we, input logic [31:0] a,
                        input logic [31:0] wd);
      logic [31:0] erd;
      logic        eerr;
      chk("z_idle_ready", 32'(req_ready_z), 32'd1);
      req_valid_z = 1'b1;
      req_we_z    = we;
      req_addr_z  = a;
      req_wdata_z = wd;
      rsp_ready_z = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_z = 1'b0;
      model(1'b1, we, a, wd, erd, eerr);
      chk("z_valid_next_edge", 32'(rsp_valid_z), 32'd1);
      chk("z_rdata", rsp_rdata_z, erd);
      chk("z_err", 32'(rsp_err_z), 32'(eerr));
      @(negedge clk);
      cnt_z++;
      chk("z_drop", 32'(rsp_valid_z), 32'd0);
      chk("z_cnt", 32'(acc_cnt_z), 32'(cnt_z));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int last, n_acc, hs, b;
      logic [31:0] old5;
      RN = 1'b0;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
      req_valid_z = 0; req_we_z = 0; req_addr_z = 0; req_wdata_z = 0;
      rsp_ready_z = 0;
      cnt_m = '0;
      cnt_z = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk("rst_cnt", 32'(acc_cnt), 32'd0);
      RN = 1'b1;
      @(negedge clk);

      // write then held read of the same word
      txn(1'b1, 32'd3, 32'hDEAD_BEEF, 0);
      chk("t1_cnt_one", 32'(acc_cnt), 32'd1);
      txn(1'b0, 32'd3, 32'd0, 4);
      chk("t2_readback", rsp_rdata, 32'hDEAD_BEEF);

      for (int a = 0; a < 32; a++)
         if (a != 3) txn(1'b1, 32'(a), $urandom, 0);

      // out-of-range read and write
      txn(1'b0, 32'd40, 32'd0, 0);
      txn(1'b1, 32'd32, 32'h1234_5678, 0);
      txn(1'b0, 32'd0, 32'd0, 0);
      txn(1'b0, 32'hFFFF_FFE0, 32'd0, 0);

      for (int i = 0; i < 40; i++)
         txn(1'(($urandom & 1)), 32'($urandom_range(0, 39)), $urandom,
             $urandom_range(0, 3));

      // back-to-back requests with req_valid held high
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'd3;
      rsp_ready = 1'b1;
      last  = -1;
      n_acc = 0;
      hs    = 0;
      for (int c = 0; c < 6 * (W + 2); c++) begin
         if (rsp_valid) begin
            chk("stream_ready_low", 32'(req_ready), 32'd0);
            chk("stream_rdata", rsp_rdata, mem_m[3]);
         end
         if (req_valid && req_ready) begin
            if (last >= 0) chk("accept_gap", 32'(c - last), 32'(W + 2));
            last = c;
            n_acc++;
         end
         if (rsp_valid && rsp_ready) hs++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      b = 0;
      while (!req_ready && b < 10) begin
         if (rsp_valid && rsp_ready) hs++;
         @(negedge clk);
         b++;
      end
      rsp_ready = 1'b0;
      cnt_m = cnt_m + 16'(hs);
      chk("stream_accepts", 32'(n_acc), 32'd6);
      chk("stream_cnt", 32'(acc_cnt), 32'(cnt_m));

      // reset before the write's access edge
      old5 = mem_m[5];
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'd5;
      req_wdata = 32'd7;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      RN = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_cnt", 32'(acc_cnt), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      RN = 1'b1;
      cnt_m = '0;
      @(negedge clk);
      txn(1'b0, 32'd5, 32'd0, 0);
      chk("mid_rst_mem5", rsp_rdata, old5);

      // zero-wait instance, counter wraps after 17 responses
      for (int i = 0; i < 17; i++) begin
         if (i % 2 == 0) txn_z(1'b1, 32'(i / 2), $urandom);
         else            txn_z(1'b0, 32'(i / 2), 32'd0);
      end
      chk("z_wrap", 32'(acc_cnt_z), 32'd1);
      txn_z(1'b0, 32'd33, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
